// File: rtl/gate_truth_table_checker_pkg.sv
// Shared types and constants for the gate truth-table checker.
// Optional capture port is enabled by defining GATE_CHECK_CAPTURE_EN.
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_N_INPUTS = 4;
    localparam int SETTLE_W     = 4;

    localparam logic [3:0] NOR_TT = 4'b0001;

endpackage

// File: rtl/gate_truth_table_checker_if.sv
// Stimulus/response bundle between the checker and the gate under test.
// Carries observed_tt only when GATE_CHECK_CAPTURE_EN is defined.
interface gate_check_if #(
    parameter int N_INPUTS = 2
);
    logic                           start;
    logic [N_INPUTS-1:0]            stim;
    logic                           dut_y;
    logic                           busy;
    logic                           done;
    logic                           pass;
    logic [N_INPUTS:0]              fail_count;
    logic [N_INPUTS-1:0]            first_fail_code;
`ifdef GATE_CHECK_CAPTURE_EN
    logic [(1<<N_INPUTS)-1:0]       observed_tt;

    modport master (
        input  start, dut_y,
        output stim, busy, done, pass, fail_count, first_fail_code, observed_tt
    );
    modport slave (
        output start, dut_y,
        input  stim, busy, done, pass, fail_count, first_fail_code, observed_tt
    );
`else
    modport master (
        input  start, dut_y,
        output stim, busy, done, pass, fail_count, first_fail_code
    );
    modport slave (
        output start, dut_y,
        input  stim, busy, done, pass, fail_count, first_fail_code
    );
`endif
endinterface

// File: rtl/gate_truth_table_checker_settle_timer.sv
// Loadable down-counter; expire is high whenever the count has reached zero.
module settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         expire
);

    logic [W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/gate_truth_table_checker.sv
// Sweeps every input code into a gate, samples its output after a settle
// window and scores it against EXPECTED_TT. Define GATE_CHECK_CAPTURE_EN for observed_tt.
module gate_truth_table_checker
    import gate_check_pkg::*;
#(
    parameter int                       N_INPUTS      = 2,
    parameter logic [(1<<N_INPUTS)-1:0] EXPECTED_TT   = NOR_TT,
    parameter int                       SETTLE_CYCLES = 2
) (
    input logic          clk,
    input logic          rst_n,
    gate_check_if.master bus
);

    localparam logic [N_INPUTS-1:0] LAST_CODE   = '1;
    localparam logic [N_INPUTS-1:0] CODE_ONE    = N_INPUTS'(1);
    localparam logic [N_INPUTS:0]   COUNT_ONE   = (N_INPUTS+1)'(1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

    state_t              state_q, state_d;
    logic [N_INPUTS-1:0] code_q, code_d;
    logic [N_INPUTS:0]   fail_count_q, fail_count_d;
    logic [N_INPUTS-1:0] first_fail_q, first_fail_d;
    logic                fail_seen_q, fail_seen_d;
    logic                pass_q, pass_d;
    logic                timer_load;
    logic                timer_expire;
    logic                mismatch;
`ifdef GATE_CHECK_CAPTURE_EN
    logic [(1<<N_INPUTS)-1:0] observed_q, observed_d;
`endif

    settle_timer #(
        .W(SETTLE_W)
    ) u_settle_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (timer_load),
        .load_value(SETTLE_LOAD),
        .expire    (timer_expire)
    );

    assign mismatch = (bus.dut_y != EXPECTED_TT[code_q]);

    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a variable unassigned (no inferred latches).
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;
        fail_seen_d  = fail_seen_q;
        pass_d       = pass_q;
        timer_load   = 1'b0;
`ifdef GATE_CHECK_CAPTURE_EN
        observed_d   = observed_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d      = RUN;
                    code_d       = '0;
                    fail_count_d = '0;
                    first_fail_d = '0;
                    fail_seen_d  = 1'b0;
                    pass_d       = 1'b0;
                    timer_load   = 1'b1;
`ifdef GATE_CHECK_CAPTURE_EN
                    observed_d   = '0;
`endif
                end
            end
            RUN: begin
                // Expiry marks the last edge of the hold window: sample and advance.
                if (timer_expire) begin
                    if (mismatch) begin
                        fail_count_d = fail_count_q + COUNT_ONE;
                        if (!fail_seen_q) begin
                            first_fail_d = code_q;
                            fail_seen_d  = 1'b1;
                        end
                    end
`ifdef GATE_CHECK_CAPTURE_EN
                    observed_d[code_q] = bus.dut_y;
`endif
                    if (code_q == LAST_CODE) begin
                        state_d = DONE;
                        code_d  = '0;
                        pass_d  = (fail_count_d == '0);
                    end else begin
                        code_d     = code_q + CODE_ONE;
                        timer_load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the reset branch covers every register here; a mid-sweep reset
    // must discard partial results, so nothing is left unreset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            code_q       <= '0;
            fail_count_q <= '0;
            first_fail_q <= '0;
            fail_seen_q  <= 1'b0;
            pass_q       <= 1'b0;
`ifdef GATE_CHECK_CAPTURE_EN
            observed_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
            fail_seen_q  <= fail_seen_d;
            pass_q       <= pass_d;
`ifdef GATE_CHECK_CAPTURE_EN
            observed_q   <= observed_d;
`endif
        end
    end

    assign bus.stim            = code_q;
    assign bus.busy            = (state_q == RUN);
    assign bus.done            = (state_q == DONE);
    assign bus.pass            = pass_q;
    assign bus.fail_count      = fail_count_q;
    assign bus.first_fail_code = first_fail_q;
`ifdef GATE_CHECK_CAPTURE_EN
    assign bus.observed_tt     = observed_q;
`endif

endmodule
